// File: rtl/fixed_predictor_decoder.sv
// Fixed-predictor (orders 0-4) sample reconstruction: warm-up samples pass through,
// then each residual is added to a polynomial prediction over the last four outputs.
module fixed_predictor_decoder #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 20
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iStart,
  input  logic [2:0]                 iOrder,
  input  logic [15:0]                iBlockSize,
  input  logic                       iValid,
  input  logic signed [SAMPLE_W-1:0] iData,
  output logic signed [SAMPLE_W-1:0] oData,
  output logic                       oValid,
  output logic                       oDone,
  output logic                       oError,
  output logic                       oBusy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] DECODE = 2'd2;

  logic [1:0]                 state;
  logic [2:0]                 order_q;
  logic [15:0]                block_size_q;
  logic [15:0]                count;
  logic signed [SAMPLE_W-1:0] s1, s2, s3, s4;

  logic signed [ACC_W-1:0]    e1, e2, e3, e4;
  logic signed [ACC_W-1:0]    pred_p0;
  logic signed [ACC_W-1:0]    sum_p0;
  logic signed [SAMPLE_W-1:0] sample_p0;
  logic                       vld_p0;
  logic                       last_p0;
  logic                       start_ok_p0;
  logic [15:0]                count_next;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [SAMPLE_W-1:0] v);
    return ACC_W'(v);
  endfunction

  // Two's-complement wrap: keep the low SAMPLE_W bits of the accumulator.
  function automatic logic signed [SAMPLE_W-1:0] wrap_sample(input logic signed [ACC_W-1:0] acc);
    return SAMPLE_W'(acc);
  endfunction

  // Stage p0: prediction, residual add and end-of-subframe detection
  always_comb begin
    e1          = sext(s1);
    e2          = sext(s2);
    e3          = sext(s3);
    e4          = sext(s4);
    pred_p0     = '0;
    case (order_q)
      3'd1:    pred_p0 = e1;
      3'd2:    pred_p0 = (e1 <<< 1) - e2;
      3'd3:    pred_p0 = ((e1 <<< 1) + e1) - ((e2 <<< 1) + e2) + e3;
      3'd4:    pred_p0 = (e1 <<< 2) - ((e2 <<< 2) + (e2 <<< 1)) + (e3 <<< 2) - e4;
      default: pred_p0 = '0;
    endcase
    sum_p0      = sext(iData) + pred_p0;
    sample_p0   = (state == DECODE) ? wrap_sample(sum_p0) : iData;
    vld_p0      = iValid && ((state == WARMUP) || (state == DECODE));
    count_next  = count + 16'd1;
    last_p0     = vld_p0 && (count_next == block_size_q);
    start_ok_p0 = iStart && (state == IDLE) && !oBusy;
  end

  // Stage p1: registered outputs, history shift and control
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state        <= IDLE;
      order_q      <= '0;
      block_size_q <= '0;
      count        <= '0;
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      s4           <= '0;
      oData        <= '0;
      oValid       <= 1'b0;
      oDone        <= 1'b0;
      oError       <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      oValid <= vld_p0;
      oDone  <= last_p0;
      if (vld_p0) begin
        oData <= sample_p0;
        s1    <= sample_p0;
        s2    <= s1;
        s3    <= s2;
        s4    <= s3;
        count <= count_next;
      end
      if (oDone) oBusy <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok_p0) begin
            if (iOrder > 3'd4) begin
              oError <= 1'b1;
            end else begin
              order_q      <= iOrder;
              block_size_q <= iBlockSize;
              count        <= '0;
              s1           <= '0;
              s2           <= '0;
              s3           <= '0;
              s4           <= '0;
              oError       <= 1'b0;
              oBusy        <= 1'b1;
              state        <= (iOrder == 3'd0) ? DECODE : WARMUP;
            end
          end
        end
        WARMUP: begin
          // A block no longer than the order finishes without entering DECODE.
          if (last_p0) state <= IDLE;
          else if (vld_p0 && (count_next == {13'd0, order_q})) state <= DECODE;
        end
        DECODE: begin
          if (last_p0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
